// File: rtl/led_uart_ctrl.sv
// led_uart_ctrl: ASCII command parser driving 8 LEDs.
// 'L'hh writes a manual LED value, 'B' returns to the blink counter,
// 'R' reads the LED register back as two uppercase hex characters.
// Responses leave through a valid/ready byte handshake.
module led_uart_ctrl #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] led,
    output logic       mode
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, HEX_HI, HEX_LO, TX1, TX2} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] count;
    logic [7:0]       manual;
    logic [3:0]       hi;
    logic [7:0]       byte0;   // first byte of a two-byte reply (TX2)
    logic [7:0]       byte1;   // single reply byte, or second byte of a read
    logic [TW-1:0]    tmo;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ||
               (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] b);
        if (b <= 8'h39)      return 4'(b - 8'h30);
        else if (b <= 8'h46) return 4'(b - 8'h37);
        else                 return 4'(b - 8'h57);
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    logic rx_hex, is_l, is_b, is_r, in_hex, tmo_hit;
    logic [3:0] rx_nib;

    assign rx_hex  = is_hex(rx_data);
    assign rx_nib  = hex_val(rx_data);
    assign is_l    = (rx_data == 8'h4C) || (rx_data == 8'h6C);
    assign is_b    = (rx_data == 8'h42) || (rx_data == 8'h62);
    assign is_r    = (rx_data == 8'h52) || (rx_data == 8'h72);
    assign in_hex  = (state == HEX_HI) || (state == HEX_LO);
    // A byte arriving on the final cycle still counts; abort only when silent.
    assign tmo_hit = (tmo == TW'(TIMEOUT_CYCLES - 1)) && !rx_valid;

    // State register
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; bytes received while replying are simply ignored
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (is_l)      state_nx = HEX_HI;
                    else if (is_b) state_nx = TX1;
                    else if (is_r) state_nx = TX2;
                end
            end
            HEX_HI: begin
                if (rx_valid)     state_nx = rx_hex ? HEX_LO : TX1;
                else if (tmo_hit) state_nx = IDLE;
            end
            HEX_LO: begin
                if (rx_valid)     state_nx = TX1;
                else if (tmo_hit) state_nx = IDLE;
            end
            TX2:     if (tx_ready) state_nx = TX1;
            TX1:     if (tx_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: reply bytes are held in registers, so tx_data is stable while stalled
    always_comb begin
        tx_valid = (state == TX1) || (state == TX2);
        tx_data  = 8'h00;
        if (state == TX2)      tx_data = byte0;
        else if (state == TX1) tx_data = byte1;
    end

    // Free-running blink counter and registered LED drive
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            count <= '0;
            led   <= 8'h00;
        end else begin
            count <= count + WIDTH'(1);
            led   <= mode ? manual : count[WIDTH-1 -: 8];
        end
    end

    // Partial-command idle timer: runs only while waiting for hex digits
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst)                     tmo <= '0;
        else if (!in_hex || rx_valid) tmo <= '0;
        else                         tmo <= tmo + 1'b1;
    end

    // Command side effects: mode/manual updates and reply byte capture
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            mode   <= 1'b0;
            manual <= 8'h00;
            hi     <= 4'h0;
            byte0  <= 8'h00;
            byte1  <= 8'h00;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (is_b) begin
                        mode  <= 1'b0;
                        byte1 <= 8'h4B;
                    end else if (is_r) begin
                        // snapshot of led as seen in the accepting cycle
                        byte0 <= to_ascii(led[7:4]);
                        byte1 <= to_ascii(led[3:0]);
                    end
                end
                HEX_HI: begin
                    if (rx_hex) hi    <= rx_nib;
                    else        byte1 <= 8'h3F;
                end
                HEX_LO: begin
                    if (rx_hex) begin
                        manual <= {hi, rx_nib};
                        mode   <= 1'b1;
                        byte1  <= 8'h4B;
                    end else begin
                        byte1  <= 8'h3F;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_uart_ctrl.sv
// tb_led_uart_ctrl: randomized command stimulus with a reply scoreboard
// and a cycle-level model of the architectural LED/mode values.
`timescale 1ns/1ps
module tb_led_uart_ctrl;

    localparam int WIDTH = 10;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] led;
    logic       mode;

    always #10 clk = ~clk;

    led_uart_ctrl #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_50mhz(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .led(led), .mode(mode)
    );

    int checks = 0;
    int passes = 0;
    int n_xfer = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // nx_* hold the architectural mode/manual as of the current command byte;
    // they become visible one cycle later, the LED one cycle after that.
    logic [7:0] exp_q[$];
    logic       nx_mode = 1'b0;
    logic [7:0] nx_manual = 8'h00;
    logic       m_mode;
    logic [7:0] m_manual, exp_led;
    logic [WIDTH-1:0] m_count;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count <= '0; m_mode <= 1'b0; m_manual <= 8'h00; exp_led <= 8'h00;
        end else begin
            m_count  <= m_count + 1'b1;
            m_mode   <= nx_mode;
            m_manual <= nx_manual;
            exp_led  <= m_mode ? m_manual : 8'(m_count >> (WIDTH - 8));
        end
    end

    // ---------------- ready driver ----------------
    logic rdy_force_en = 1'b1;
    logic rdy_force    = 1'b1;
    always @(posedge clk) begin
        #1;
        tx_ready = rdy_force_en ? rdy_force : ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitor ----------------
    logic       prev_pend = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_pend <= 1'b0;
        end else begin
            chk("led", {24'h0, led}, {24'h0, exp_led});
            chk("mode", {31'h0, mode}, {31'h0, m_mode});
            if (prev_pend) begin
                chk("hold_valid", {31'h0, tx_valid}, 32'd1);
                chk("hold_data", {24'h0, tx_data}, {24'h0, prev_data});
            end
            if (tx_valid) begin
                chk("tx_expected", {31'h0, exp_q.size() != 0}, 32'd1);
                if (tx_ready && exp_q.size() != 0) begin
                    chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                    n_xfer <= n_xfer + 1;
                end
            end
            prev_pend <= tx_valid && !tx_ready;
            prev_data <= tx_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic is_hexc(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic logic [7:0] upper_hex(input logic [3:0] n);
        return (n < 10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
    endfunction

    function automatic logic [7:0] rand_hexc(input logic [3:0] n);
        if (n >= 10 && $urandom_range(0, 1) == 1) return 8'h61 + 8'(n) - 8'd10;
        return upper_hex(n);
    endfunction

    function automatic logic [7:0] rand_nonhex();
        logic [7:0] b;
        do b = 8'($urandom); while (is_hexc(b));
        return b;
    endfunction

    function automatic logic [7:0] rand_noncmd();
        logic [7:0] b;
        do b = 8'($urandom);
        while (b == "L" || b == "l" || b == "B" || b == "b" || b == "R" || b == "r");
        return b;
    endfunction

    // present one byte in the next cycle; caller applies its effect in that cycle
    task automatic put(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx_valid = 1'b0; rx_data = 8'($urandom);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic gap();
        idle($urandom_range(0, 10));
    endtask

    task automatic do_write(input logic [7:0] v);
        put($urandom_range(0, 1) ? "L" : "l"); gap();
        put(rand_hexc(v[7:4])); gap();
        put(rand_hexc(v[3:0]));
        nx_mode = 1'b1; nx_manual = v; exp_q.push_back("K");
        idle(1); drain();
    endtask

    task automatic do_read();
        put($urandom_range(0, 1) ? "R" : "r");
        exp_q.push_back(upper_hex(exp_led[7:4]));
        exp_q.push_back(upper_hex(exp_led[3:0]));
        idle(1); drain();
    endtask

    task automatic do_blink();
        put($urandom_range(0, 1) ? "B" : "b");
        nx_mode = 1'b0; exp_q.push_back("K");
        idle(1); drain();
    endtask

    task automatic do_err(input logic at_lo);
        put("L"); gap();
        if (at_lo) begin put(rand_hexc(4'($urandom))); gap(); end
        put(rand_nonhex());
        exp_q.push_back("?");
        idle(1); drain();
    endtask

    task automatic do_timeout();
        put("L");
        if ($urandom_range(0, 1)) begin gap(); put(rand_hexc(4'($urandom))); end
        idle(TMO + 4);
    endtask

    // ---------------- main sequence ----------------
    int x0;
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_mode", {31'h0, mode}, 32'h0);
        chk("rst_txv", {31'h0, tx_valid}, 32'h0);
        chk("rst_txd", {24'h0, tx_data}, 32'h0);
        #2 rst = 1'b0;

        // blink tracking: led steps every 4 cycles with WIDTH = 10
        idle(40);

        // manual write 'L','a','5' then read back
        put("L"); put("a"); put("5");
        nx_mode = 1'b1; nx_manual = 8'hA5; exp_q.push_back(8'h4B);
        idle(1); drain();
        idle(2);
        put("R"); exp_q.push_back(8'h41); exp_q.push_back(8'h35);
        idle(1); drain();

        // error paths and ignored CR/LF
        put("L"); put("G"); exp_q.push_back(8'h3F); idle(1); drain();
        put("L"); put("3"); put("x"); exp_q.push_back(8'h3F); idle(1); drain();
        put(8'h0D); put(8'h0A); idle(4);

        // handshake stall with a dropped byte
        rdy_force = 1'b0;
        idle(1);
        x0 = n_xfer;
        put("R");
        exp_q.push_back(upper_hex(exp_led[7:4]));
        exp_q.push_back(upper_hex(exp_led[3:0]));
        idle(5); put("L"); idle(14);
        rdy_force = 1'b1;
        drain();
        idle(2);
        chk("stall_xfers", n_xfer - x0, 32'd2);
        put("A"); idle(2); put("5"); idle(6);   // replies here would mean 'L' was parsed

        // timeout: 'L', 16 silent cycles, then '5' must be ignored
        put("L"); idle(TMO); put("5"); idle(6);
        put("B"); nx_mode = 1'b0; exp_q.push_back(8'h4B); idle(1); drain();

        // blink wrap: led passes 0xFF -> 0x00
        idle(1100);

        // randomized traffic with random ready
        rdy_force_en = 1'b0;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    do_write(8'($urandom));
                2:       do_read();
                3:       do_blink();
                4:       do_err(1'b0);
                5:       do_err(1'b1);
                6:       begin put(rand_noncmd()); idle(2); end
                default: do_timeout();
            endcase
        end

        // reset mid-operation with a stalled reply pending
        rdy_force_en = 1'b1; rdy_force = 1'b1;
        idle(1);
        do_write(8'h3C);
        rdy_force = 1'b0;
        idle(1);
        put("R");
        exp_q.push_back(upper_hex(exp_led[7:4]));
        exp_q.push_back(upper_hex(exp_led[3:0]));
        idle(4);
        @(negedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_led", {24'h0, led}, 32'h0);
        chk("arst_mode", {31'h0, mode}, 32'h0);
        chk("arst_txv", {31'h0, tx_valid}, 32'h0);
        exp_q.delete();
        nx_mode = 1'b0; nx_manual = 8'h00;
        rdy_force = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        idle(30);
        chk("final_q", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
